// File: rtl/div_xxbit_restoring.sv
// div_xxbit_restoring
// Multi-cycle restoring shift-subtract divider, signed or unsigned, one
// quotient bit per clock.
//
// A division runs through three states. IDLE accepts a request. CALC takes
// DATA_WIDTH cycles. FIX registers the results and pulses o_end. The divider
// works only on magnitudes. Result signs are captured at accept time and
// applied in FIX.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_start     request; accepted only while o_busy = 0
//   i_sgn       1 = signed two's-complement, 0 = unsigned (sampled with i_start)
//   i_num_a     dividend (sampled with i_start)
//   i_num_b     divisor  (sampled with i_start)
//   o_busy      division in progress
//   o_end       one-cycle completion pulse
//   o_quo       quotient  (held until the next completion)
//   o_rem       remainder (held until the next completion)
//   o_div_zero  divisor was zero (held until the next completion)
module div_xxbit_restoring #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_sgn,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    output logic                  o_busy,
    output logic                  o_end,
    output logic [DATA_WIDTH-1:0] o_quo,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic                  o_div_zero
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q;
    logic [N-1:0]   dvd_q;    // dividend, shifted left; quotient bits fill in from the LSB
    logic [N-1:0]   dvs_q;    // divisor magnitude
    logic [N-1:0]   rem_q;    // partial remainder (always < divisor, so N bits suffice)
    logic           q_neg_q;
    logic           r_neg_q;
    logic           dz_q;
    logic [CW-1:0]  cnt_q;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     shift_w, diff_w;
    logic [N-1:0]   rem_d, dvd_d;

    always_comb begin
        a_neg = i_sgn & i_num_a[N-1];
        b_neg = i_sgn & i_num_b[N-1];
        // -2^(N-1) maps to itself here, which is its correct unsigned magnitude
        a_mag = a_neg ? -i_num_a : i_num_a;
        b_mag = b_neg ? -i_num_b : i_num_b;

        // One restoring step. shift_w can reach 2*|b|-1, so it needs N+1 bits.
        // The sign bit of diff_w is the trial-subtract borrow.
        shift_w = {rem_q, dvd_q[N-1]};
        diff_w  = shift_w - {1'b0, dvs_q};
        if (diff_w[N]) begin
            rem_d = shift_w[N-1:0];
            dvd_d = {dvd_q[N-2:0], 1'b0};
        end else begin
            rem_d = diff_w[N-1:0];
            dvd_d = {dvd_q[N-2:0], 1'b1};
        end
    end

    assign o_busy = (state_q != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            cnt_q      <= '0;
            o_end      <= 1'b0;
            o_quo      <= '0;
            o_rem      <= '0;
            o_div_zero <= 1'b0;
        end else begin
            o_end <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        dvs_q   <= b_mag;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        if (i_num_b == '0) begin
                            // Keep the raw dividend; it is returned untouched as the remainder
                            dz_q    <= 1'b1;
                            dvd_q   <= i_num_a;
                            state_q <= FIX;
                        end else begin
                            dz_q    <= 1'b0;
                            dvd_q   <= a_mag;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    o_end      <= 1'b1;
                    o_div_zero <= dz_q;
                    if (dz_q) begin
                        o_quo <= '1;
                        o_rem <= dvd_q;
                    end else begin
                        o_quo <= q_neg_q ? -dvd_q : dvd_q;
                        o_rem <= r_neg_q ? -rem_q : rem_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_xxbit_restoring.sv
module tb_div_xxbit_restoring;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, endp, dz;
    logic [N-1:0] quo, rem;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_xxbit_restoring #(.DATA_WIDTH(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sgn(sgn),
        .i_num_a(a), .i_num_b(b),
        .o_busy(busy), .o_end(endp), .o_quo(quo), .o_rem(rem), .o_div_zero(dz)
    );

    // Reference result {div_zero, quotient, remainder} from plain integer arithmetic
    function automatic logic [2*N:0] ref_div(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        int sx, sy, q, r;
        if (y == '0) return {1'b1, {N{1'b1}}, x};
        if (s) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        q = sx / sy;
        r = sx % sy;
        return {1'b0, q[N-1:0], r[N-1:0]};
    endfunction

    // Transaction-level model: edges remaining until completion, plus held results
    int           m_left = 0;
    logic         m_end = 1'b0, m_dz = 1'b0;
    logic [N-1:0] m_quo = '0, m_rem = '0;
    logic [2*N:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0; m_end <= 1'b0; m_dz <= 1'b0; m_quo <= '0; m_rem <= '0;
        end else if (m_left == 0) begin
            m_end <= 1'b0;
            if (start) begin
                m_pend <= ref_div(sgn, a, b);
                m_left <= (b == '0) ? 1 : N + 1;
            end
        end else begin
            m_end  <= (m_left == 1);
            if (m_left == 1) {m_dz, m_quo, m_rem} <= m_pend;
            m_left <= m_left - 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every DUT output against the model
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, endp, dz, quo, rem} !== {m_left != 0, m_end, m_dz, m_quo, m_rem}) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got busy=%b end=%b dz=%b q=%h r=%h expected busy=%b end=%b dz=%b q=%h r=%h",
                     $time, busy, endp, dz, quo, rem, m_left != 0, m_end, m_dz, m_quo, m_rem);
        end
    endtask

    // Issue one division and wait (bounded) for o_end; checks hand-computed literals
    task automatic run(input string name, input logic s, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz, input int elat);
        int lat;
        sgn = s; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!endp && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, elat);
        check({name, "_quo"}, int'(quo), int'(eq));
        check({name, "_rem"}, int'(rem), int'(er));
        check({name, "_dz"}, int'(dz), int'(edz));
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_end", int'(endp), 0);
        check("reset_quo", int'(quo), 0);
        check("reset_rem", int'(rem), 0);

        run("u10d3",  1'b0, 4'd10,    4'd3,    4'b0011, 4'b0001, 1'b0, 5);
        run("sm7d2",  1'b1, 4'b1001,  4'd2,    4'b1101, 4'b1111, 1'b0, 5);
        run("sm6d3",  1'b1, 4'b1010,  4'd3,    4'b1110, 4'b0000, 1'b0, 5);
        run("s7dm2",  1'b1, 4'd7,     4'b1110, 4'b1101, 4'b0001, 1'b0, 5);
        run("ovf",    1'b1, 4'b1000,  4'b1111, 4'b1000, 4'b0000, 1'b0, 5);
        run("u5d0",   1'b0, 4'd5,     4'd0,    4'b1111, 4'b0101, 1'b1, 1);
        run("s5d0",   1'b1, 4'd5,     4'd0,    4'b1111, 4'b0101, 1'b1, 1);
        run("u15d1",  1'b0, 4'd15,    4'd1,    4'b1111, 4'b0000, 1'b0, 5);

        // Start plus operand changes while busy must be ignored
        sgn = 1'b0; a = 4'd9; b = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 4'd15; b = 4'd1;
        tick();
        start = 1'b0; a = 4'd0; b = 4'd0;
        for (int i = 0; i < 20 && !endp; i++) tick();
        check("busy_ign_quo", int'(quo), 4);
        check("busy_ign_rem", int'(rem), 1);
        // Start in the o_end cycle is accepted back-to-back
        run("b2b",    1'b0, 4'd12,    4'd5,    4'b0010, 4'b0010, 1'b0, 5);
        tick(); tick();
        check("hold_quo", int'(quo), 2);
        check("hold_rem", int'(rem), 2);

        // Reset at E3 aborts the division; reset beats a simultaneous start
        sgn = 1'b0; a = 4'd13; b = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_quo", int'(quo), 0);
        check("abort_rem", int'(rem), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_end", int'(endp), 0);
        end
        run("post_rst", 1'b0, 4'd13,  4'd3,    4'b0100, 4'b0001, 1'b0, 5);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_xxbit_restoring.md
DIV_XXBIT_RESTORING -- requirements
Module: div_xxbit_restoring

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand/result width N; legal N >= 2.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  request; accepted only when o_busy=0.
REQ-005 i_sgn  input  1  1 = signed two's-complement divide, 0 = unsigned; sampled with i_start.
REQ-006 i_num_a  input  N  dividend; sampled with i_start.
REQ-007 i_num_b  input  N  divisor; sampled with i_start.
REQ-008 o_busy  output  1  high while a division is in progress (state != IDLE).
REQ-009 o_end  output  1  one-cycle completion pulse; o_quo/o_rem valid in that cycle.
REQ-010 o_quo  output  N  quotient.
REQ-011 o_rem  output  N  remainder.
REQ-012 o_div_zero  output  1  divisor was zero; valid with o_end.

Function
REQ-013 The block SHALL implement a restoring shift-subtract divider with one quotient bit per cycle, states IDLE, CALC, FIX.
REQ-014 IDLE: at edge E0 with i_start=1 the block SHALL latch i_sgn, |a|, |b| (magnitudes as N-bit unsigned; unsigned mode uses raw values), record result signs (q_neg = a_sign XOR b_sign, r_neg = a_sign, both 0 when i_sgn=0), clear a counter, and go to CALC.
REQ-015 CALC: each edge SHALL shift {partial remainder, dividend} left by one, trial-subtract |b| from the N+1-bit partial remainder, keep the difference and set quotient LSB=1 if non-negative, else restore and set LSB=0.
REQ-016 CALC SHALL last exactly N edges (E1..EN), then go to FIX.
REQ-017 FIX: at edge E(N+1) the block SHALL register o_quo (negated if q_neg) and o_rem (negated if r_neg), set o_end=1 for one cycle, and return to IDLE.
REQ-018 Latency SHALL be N+1 edges from the accepting edge to the cycle where o_end=1; throughput one result per N+1 cycles.
REQ-019 Signed semantics SHALL truncate toward zero; remainder sign SHALL equal dividend sign; a = q*b + r SHALL hold modulo 2^N.
REQ-020 Signed overflow (a = -2^(N-1), b = -1) SHALL yield o_quo = -2^(N-1), o_rem = 0, o_div_zero = 0, with no special-case latency.
REQ-021 Divisor zero: the accepting edge SHALL go directly to FIX; at the next edge o_quo = all ones, o_rem = i_num_a as sampled (unmodified), o_div_zero = 1, o_end = 1 (latency 1 edge).
REQ-022 o_div_zero SHALL be 0 for every non-zero divisor result and SHALL update only at FIX.
REQ-023 i_start while o_busy=1 SHALL be ignored; operand changes during a division SHALL not affect the result.
REQ-024 i_start in the cycle where o_end=1 SHALL be accepted (block is IDLE), giving back-to-back operation.
REQ-025 o_quo, o_rem, o_div_zero SHALL hold their values until the next FIX edge.
REQ-026 o_busy SHALL be 1 in every cycle from the one after E0 through the one before o_end=1, and 0 in the o_end cycle.

Reset
REQ-027 While i_rst=1 at an edge, state SHALL become IDLE and o_busy, o_end, o_quo, o_rem, o_div_zero, counter and internal registers SHALL become 0.
REQ-028 i_rst asserted mid-division SHALL abort it with no o_end pulse; i_rst has priority over i_start in the same cycle.

Verification (N=4)
REQ-029 Unsigned 10 / 3 (i_sgn=0) -> o_end exactly 5 edges after accept, o_quo=0011, o_rem=0001, o_div_zero=0.
REQ-030 Signed -7 / 2 -> o_quo=1101 (-3), o_rem=1111 (-1); signed -6 / 3 -> o_quo=1110, o_rem=0000.
REQ-031 Signed -8 / -1 -> o_quo=1000, o_rem=0000, o_div_zero=0, latency 5 edges.
REQ-032 5 / 0 (either mode) -> o_end 1 edge after accept, o_quo=1111, o_rem=0101, o_div_zero=1.
REQ-033 Second i_start and changed operands pulsed 2 cycles after accept -> ignored, first result unaffected; i_start held in the o_end cycle -> new division accepted.
REQ-034 i_rst=1 at edge E3 of a division -> all outputs 0, no o_end; a fresh start afterwards completes correctly.
